id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the `execution` ALU. It registers decoded operands and control from the decode stage, then applies EX/MEM and MEM/WB forwarding to present the final `d1_in`/`d2_in` operands and `aluctrl` to the ALU. It also detects load-use hazards, raising a stall to decode while inserting a bubble, and supports a flush for taken branches.

## Interface
- No parameters. The data width is fixed at 32 bits and register indices at 5 bits.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the decode stage holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in 5: register indices.
- `id_rs_data`, `id_rt_data` in 32: register file read data.
- `id_imm` in 32: sign- or zero-extended immediate.
- `id_shamt` in 5: shift amount.
- `id_aluctrl` in 5: ALU operation code, passed through unchanged.
- `id_alusrc` in 1: selects d2; 1 = imm, 0 = rt.
- `id_shift` in 1: 1 = d1 is rt and d2 is zero-extended shamt.
- `id_regdst` in 1: selects dest; 1 = rd, 0 = rt.
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg` in 1: control bits.
- `flush` in 1: squash the instruction entering EX next cycle.
- `exmem_regwrite` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_regwrite` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forwarding source.
- `stall` out 1: load-use hazard; decode and fetch must hold.
- `ex_valid` out 1: EX holds a real instruction.
- `d1_out`, `d2_out` out 32: forwarded ALU operands, driving `d1_in`/`d2_in`.
- `ex_aluctrl` out 5: ALU operation code.
- `ex_store_data` out 32: forwarded rt value for stores.
- `ex_dest` out 5: destination register index.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg` out 1: registered control bits.

## Operation
- **Capture.** Each rising edge loads one of three things:
  - a real instruction: all `id_*` fields, with `ex_dest = id_regdst ? id_rd : id_rt`;
  - a bubble: valid, all control bits, dest and `aluctrl` = 0; data fields = 0;
  - nothing, only under reset.
- **Capture priority:**
  1. `rst` gives the all-zero state.
  2. `flush` loads a bubble.
  3. `stall` loads a bubble.
  4. `!id_valid` loads a bubble.
  5. Otherwise the real instruction is loaded.
- **Dest 0.** When the captured dest equals 0, `ex_regwrite` is captured as 0.
- **Load-use hazard.** `stall = ex_valid & ex_memread & id_valid & (ex_dest != 0) & (ex_dest == id_rs | ex_dest == id_rt)`.
  - `stall` is combinational from the registered state and the `id_*` inputs.
  - `flush` does not gate `stall`, but flush wins for capture.
- **Forwarding** is combinational, applied separately to the registered rs and rt sources (`fwd_rs`, `fwd_rt`):
  - Use `exmem_result` if `exmem_regwrite & exmem_rd != 0 & exmem_rd == src`.
  - Else use `memwb_result` if `memwb_regwrite & memwb_rd != 0 & memwb_rd == src`.
  - Else use the registered register-file data.
  - EX/MEM beats MEM/WB when both match.
- **Operand select:**
  - `d1_out = ex_shift ? fwd_rt : fwd_rs`.
  - `d2_out = ex_shift ? {27'b0, shamt} : (ex_alusrc ? imm : fwd_rt)`.
  - `ex_store_data = fwd_rt`, always.
- **Bubble outputs.** While `ex_valid = 0`, forwarding still evaluates, but downstream ignores the result because all control bits are 0.

## Timing
- **Reset.** `rst` asserts asynchronously; every output is 0 while it is high: `stall`, `ex_valid`, `d1_out`, `d2_out`, `ex_store_data`, `ex_dest`, `ex_aluctrl` and all control bits. With reset state, `d1_out`/`d2_out` are 0 unless forwarding inputs match index 0, which is excluded, so they are 0.
- **Latency.** An instruction presented on `id_*` in cycle N appears on the `ex_*` outputs in cycle N+1.
- **Forwarded operands** reflect `exmem_*`/`memwb_*` in the same cycle, with zero latency.
- **Load-use.** A hazard holds `stall` high for exactly one cycle per load.
  - Next cycle EX holds a bubble and `ex_memread` = 0, so `stall` drops.
  - Decode re-presents the held instruction, which is then captured.
- **Reset mid-stall.** All state clears immediately; `stall` drops in the same cycle.
- **Flush and stall together.** The bubble is loaded. Decode holding or discarding is the control unit's responsibility.

## Test plan
- **Reset.**
  - Stimulus: hold `rst` with `id_valid = 1` for 3 edges.
  - Required: all outputs 0. After release, the next edge loads the instruction.
- **Plain add.**
  - Stimulus: `id_rs_data = 5`, `id_rt_data = 7`, `aluctrl = 00010`, no forward match.
  - Required: next cycle `d1_out = 5`, `d2_out = 7`, `ex_valid = 1`.
- **Forward priority.**
  - Stimulus: EX holds rs = 3 (data 1). Set `exmem_rd = 3`, `exmem_result = 0x10`, `memwb_rd = 3`, `memwb_result = 0x20`.
  - Required: `d1_out = 0x10`.
  - Then drop `exmem_regwrite`: `d1_out = 0x20`.
  - Then set `memwb_rd = 0`: `d1_out = 1`.
- **Load-use.**
  - Stimulus: EX holds a `lw` with dest 4; ID holds `add` with rs = 4.
  - Required: `stall = 1`. The next edge gives `ex_valid = 0` and `stall = 0`. The following edge captures the add.
- **Flush.**
  - Stimulus: `flush = 1` with a valid `sw` in ID.
  - Required: next cycle `ex_valid = 0`, `ex_memwrite = 0`.
- **Shift and immediate.**
  - Stimulus: `id_shift = 1`, rt = 0xF0, `shamt = 4`.
  - Required: `d1_out = 0xF0`, `d2_out = 4`.
  - Stimulus: `alusrc = 1`, `imm = 0xFFFFFFFC`.
  - Required: `d2_out = 0xFFFFFFFC`.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection (stall + bubble) and branch flush.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_aluctrl,
  input  logic        id_alusrc,
  input  logic        id_shift,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] d1_out,
  output logic [31:0] d2_out,
  output logic [4:0]  ex_aluctrl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg
);

  logic        r_valid;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [31:0] r_imm;
  logic [4:0]  r_shamt;
  logic [4:0]  r_aluctrl;
  logic        r_alusrc;
  logic        r_shift;
  logic [4:0]  r_dest;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic        r_memtoreg;

  logic [4:0]  w_dest;
  logic        w_stall;
  logic        w_bubble;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  always_comb begin
    w_dest   = id_regdst ? id_rd : id_rt;
    w_stall  = r_valid & r_memread & id_valid & (r_dest != 5'd0) &
               ((r_dest == id_rs) | (r_dest == id_rt));
    w_bubble = flush | w_stall | ~id_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_bubble) begin
      r_valid    <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_shamt    <= '0;
      r_aluctrl  <= '0;
      r_alusrc   <= 1'b0;
      r_shift    <= 1'b0;
      r_dest     <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else begin
      r_valid    <= 1'b1;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_shamt    <= id_shamt;
      r_aluctrl  <= id_aluctrl;
      r_alusrc   <= id_alusrc;
      r_shift    <= id_shift;
      r_dest     <= w_dest;
      // writes to r0 are dropped here so downstream never sees them
      r_regwrite <= id_regwrite & (w_dest != 5'd0);
      r_memread  <= id_memread;
      r_memwrite <= id_memwrite;
      r_memtoreg <= id_memtoreg;
    end
  end

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == r_rs))
      w_fwd_rs = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == r_rs))
      w_fwd_rs = memwb_result;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == r_rt))
      w_fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == r_rt))
      w_fwd_rt = memwb_result;
  end

  always_comb begin
    stall         = w_stall;
    ex_valid      = r_valid;
    d1_out        = r_shift ? w_fwd_rt : w_fwd_rs;
    d2_out        = r_shift ? {27'b0, r_shamt} : (r_alusrc ? r_imm : w_fwd_rt);
    ex_store_data = w_fwd_rt;
    ex_aluctrl    = r_aluctrl;
    ex_dest       = r_dest;
    ex_regwrite   = r_regwrite;
    ex_memread    = r_memread;
    ex_memwrite   = r_memwrite;
    ex_memtoreg   = r_memtoreg;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed stimulus pushes expected output
// snapshots, a negedge monitor pops and compares them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_aluctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc, id_shift, id_regdst;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall, ex_valid;
  logic [31:0] d1_out, d2_out, ex_store_data;
  logic [4:0]  ex_aluctrl, ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluctrl(id_aluctrl), .id_alusrc(id_alusrc),
    .id_shift(id_shift), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .d1_out(d1_out), .d2_out(d2_out),
    .ex_aluctrl(ex_aluctrl), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  typedef struct {
    string       name;
    logic        st, v;
    logic [31:0] d1, d2, sd;
    logic [4:0]  dest, alu;
    logic        rw, mr, mw, mt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "stall",       {31'b0, stall},       {31'b0, e.st});
      chk(e.name, "ex_valid",    {31'b0, ex_valid},    {31'b0, e.v});
      chk(e.name, "d1_out",      d1_out,               e.d1);
      chk(e.name, "d2_out",      d2_out,               e.d2);
      chk(e.name, "store_data",  ex_store_data,        e.sd);
      chk(e.name, "ex_dest",     {27'b0, ex_dest},     {27'b0, e.dest});
      chk(e.name, "ex_aluctrl",  {27'b0, ex_aluctrl},  {27'b0, e.alu});
      chk(e.name, "ex_regwrite", {31'b0, ex_regwrite}, {31'b0, e.rw});
      chk(e.name, "ex_memread",  {31'b0, ex_memread},  {31'b0, e.mr});
      chk(e.name, "ex_memwrite", {31'b0, ex_memwrite}, {31'b0, e.mw});
      chk(e.name, "ex_memtoreg", {31'b0, ex_memtoreg}, {31'b0, e.mt});
    end
  end

  task automatic expect_out(string nm, logic st, logic v, logic [31:0] d1, logic [31:0] d2,
                            logic [31:0] sd, logic [4:0] dest, logic [4:0] alu,
                            logic rw, logic mr, logic mw, logic mt);
    exp_t e;
    e.name = nm; e.st = st; e.v = v; e.d1 = d1; e.d2 = d2; e.sd = sd;
    e.dest = dest; e.alu = alu; e.rw = rw; e.mr = mr; e.mw = mw; e.mt = mt;
    q.push_back(e);
  endtask

  task automatic expect_zero(string nm);
    expect_out(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic instr(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                       logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                       logic [4:0] sh, logic [4:0] alu, logic alusrc, logic shift,
                       logic regdst, logic rw, logic mr, logic mw, logic mt);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_aluctrl = alu; id_alusrc = alusrc; id_shift = shift; id_regdst = regdst;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lw r4, 8(r1) with r1 = 0x100
  task automatic instr_lw();
    instr(1, 4, 0, 32'h100, 0, 8, 0, 2, 1, 0, 0, 1, 1, 0, 1);
  endtask

  // add r7, r4, r6 : depends on the load
  task automatic instr_add_dep();
    instr(4, 6, 7, 32'h11, 32'h22, 0, 0, 2, 0, 0, 1, 1, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    // forwarding sources aimed at r0 must never be used
    exmem_regwrite = 1'b1; exmem_rd = 0; exmem_result = 32'hDEAD;
    memwb_regwrite = 1'b1; memwb_rd = 0; memwb_result = 32'hBEEF;
    instr(1, 2, 3, 5, 7, 0, 0, 5'b00010, 0, 0, 1, 1, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      expect_zero("reset_hold");
    end
    rst = 1'b0;
    expect_zero("reset_released");

    tick();
    expect_out("plain_add", 0, 1, 5, 7, 7, 3, 2, 1, 0, 0, 0);
    instr(3, 4, 5, 1, 9, 0, 0, 2, 0, 0, 1, 1, 0, 0, 0);

    tick();
    exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h10;
    memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h20;
    expect_out("fwd_exmem_wins", 0, 1, 32'h10, 9, 9, 5, 2, 1, 0, 0, 0);

    tick();
    exmem_regwrite = 0;
    expect_out("fwd_memwb", 0, 1, 32'h20, 9, 9, 5, 2, 1, 0, 0, 0);

    tick();
    memwb_rd = 0;
    expect_out("fwd_none", 0, 1, 1, 9, 9, 5, 2, 1, 0, 0, 0);

    tick();
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'h44;
    expect_out("fwd_rt", 0, 1, 1, 32'h44, 32'h44, 5, 2, 1, 0, 0, 0);
    instr_lw();

    tick();
    exmem_regwrite = 0; memwb_regwrite = 0;
    instr_add_dep();
    expect_out("load_use_stall", 1, 1, 32'h100, 8, 0, 4, 2, 1, 1, 0, 1);

    tick();
    expect_zero("load_use_bubble");

    tick();
    expect_out("add_after_stall", 0, 1, 32'h11, 32'h22, 32'h22, 7, 2, 1, 0, 0, 0);
    instr(2, 3, 0, 32'h30, 32'h55, 4, 0, 2, 1, 0, 0, 0, 0, 1, 0);
    flush = 1'b1;

    tick();
    flush = 1'b0;
    expect_zero("flush_bubble");

    tick();
    expect_out("sw_after_flush", 0, 1, 32'h30, 4, 32'h55, 3, 2, 0, 0, 1, 0);
    instr(1, 2, 0, 5, 7, 0, 0, 2, 0, 0, 1, 1, 0, 0, 0);

    tick();
    expect_out("dest_zero", 0, 1, 5, 7, 7, 0, 2, 0, 0, 0, 0);
    id_valid = 1'b0;

    tick();
    expect_zero("invalid_bubble");
    instr(1, 5, 8, 32'h99, 32'hF0, 0, 4, 3, 0, 1, 1, 1, 0, 0, 0);

    tick();
    expect_out("shift", 0, 1, 32'hF0, 4, 32'hF0, 8, 3, 1, 0, 0, 0);
    instr(1, 5, 8, 32'h99, 32'hF0, 32'hFFFFFFFC, 4, 2, 1, 0, 1, 1, 0, 0, 0);

    tick();
    expect_out("imm", 0, 1, 32'h99, 32'hFFFFFFFC, 32'hF0, 8, 2, 1, 0, 0, 0);
    instr_lw();

    tick();
    instr_add_dep();
    flush = 1'b1;
    expect_out("flush_with_stall", 1, 1, 32'h100, 8, 0, 4, 2, 1, 1, 0, 1);

    tick();
    flush = 1'b0;
    expect_zero("flush_stall_bubble");
    instr_lw();

    tick();
    instr_add_dep();
    expect_out("stall_before_reset", 1, 1, 32'h100, 8, 0, 4, 2, 1, 1, 0, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    expect_zero("reset_mid_stall");

    tick();
    rst = 1'b0;
    expect_zero("reset_mid_released");

    tick();
    expect_out("add_after_reset", 0, 1, 32'h11, 32'h22, 32'h22, 7, 2, 1, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
